// File: rtl/id_stage_pkg.sv
// id_stage_pkg
//   Shared decode constants for the instruction-decode stage: opcode values,
//   ALU operation encodings, instruction field positions and the packed
//   ID/EX register layout.
//   No ports (package).
package id_stage_pkg;

   // Opcodes (ir[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

   // ALU operation selects carried to EX
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // Instruction field positions
   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;

   // Control bundle produced by the decoder
   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       alu_src;
      logic [1:0] alu_op;
   } ctrl_t;

   // Full ID/EX register contents. An all-zero value is a bubble.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dst;
      logic [5:0]  funct;
      ctrl_t       ctrl;
   } idex_t;

   function automatic logic [31:0] sign_ext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// id_stage_regfile
//   32 x 32-bit register file with two combinational read ports and one
//   write port. r0 always reads zero and ignores writes. A read that hits
//   the register being written this cycle returns the write data
//   (write-through), so WB and ID can overlap without a hazard.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset (clears all)
//   we_i, waddr_i, wdata_i  write port, committed on the rising edge
//   raddr_a_i / rdata_a_o   read port A (combinational)
//   raddr_b_i / rdata_b_o   read port B (combinational)
module id_stage_regfile
   import id_stage_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  raddr_a_i,
   output logic [31:0] rdata_a_o,
   input  logic [4:0]  raddr_b_i,
   output logic [31:0] rdata_b_o
);

   logic [31:0] regs [32];
   logic        wr_en;

   // A write to r0 is treated as no write at all, both for storage and bypass.
   assign wr_en = we_i && (waddr_i != 5'd0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_a_o = regs[raddr_a_i];
      if (raddr_a_i == 5'd0) begin
         rdata_a_o = '0;
      end else if (wr_en && (raddr_a_i == waddr_i)) begin
         rdata_a_o = wdata_i;
      end
   end

   always_comb begin
      rdata_b_o = regs[raddr_b_i];
      if (raddr_b_i == 5'd0) begin
         rdata_b_o = '0;
      end else if (wr_en && (raddr_b_i == waddr_i)) begin
         rdata_b_o = wdata_i;
      end
   end

endmodule

// File: rtl/id_stage.sv
// id_stage
//   Instruction-decode stage. Decodes the IF/ID instruction, reads two
//   operands from the register file, detects load-use hazards against the
//   instruction currently in ID/EX and registers the result into ID/EX.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   IFID_pc_i, IFID_ir_i              instruction presented by fetch
//   MEM_do_branch_i                   taken branch in MEM: flush ID
//   WB_reg_write_i/WB_dst_i/WB_data_i register write-back port
//   ID_stall_o                        to fetch: hold pc and IF/ID this cycle
//   IDEX_*                            registered decode results for EX
//
// Stall semantics: ID_stall_o is a combinational request to fetch meaning
// "the instruction you are presenting was not accepted this cycle; present it
// again next cycle". It is never raised while MEM_do_branch_i is set, since
// the flush discards that instruction anyway. ID/EX itself never holds; a
// stalled cycle loads a bubble.
module id_stage
   import id_stage_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] IFID_pc_i,
   input  logic [31:0] IFID_ir_i,
   input  logic        MEM_do_branch_i,
   input  logic        WB_reg_write_i,
   input  logic [4:0]  WB_dst_i,
   input  logic [31:0] WB_data_i,
   output logic        ID_stall_o,
   output logic [31:0] IDEX_pc_o,
   output logic [31:0] IDEX_rs_data_o,
   output logic [31:0] IDEX_rt_data_o,
   output logic [31:0] IDEX_imm_o,
   output logic [4:0]  IDEX_rs_o,
   output logic [4:0]  IDEX_rt_o,
   output logic [4:0]  IDEX_dst_o,
   output logic [5:0]  IDEX_funct_o,
   output logic [1:0]  IDEX_alu_op_o,
   output logic        IDEX_alu_src_o,
   output logic        IDEX_reg_write_o,
   output logic        IDEX_mem_read_o,
   output logic        IDEX_mem_write_o,
   output logic        IDEX_branch_o
);

   logic [5:0]  op;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [31:0] imm;
   logic [31:0] rs_data;
   logic [31:0] rt_data;

   ctrl_t       ctrl_dec;
   logic [4:0]  dst_dec;
   logic        op_valid;
   logic        rt_is_source;
   logic        hazard;
   idex_t       idex_next;
   idex_t       idex_q;

   assign op    = IFID_ir_i[OP_HI:OP_LO];
   assign rs    = IFID_ir_i[RS_HI:RS_LO];
   assign rt    = IFID_ir_i[RT_HI:RT_LO];
   assign rd    = IFID_ir_i[RD_HI:RD_LO];
   assign funct = IFID_ir_i[FUNCT_HI:FUNCT_LO];
   assign imm   = sign_ext16(IFID_ir_i[IMM_HI:IMM_LO]);

   id_stage_regfile u_regfile (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (WB_reg_write_i),
      .waddr_i   (WB_dst_i),
      .wdata_i   (WB_data_i),
      .raddr_a_i (rs),
      .rdata_a_o (rs_data),
      .raddr_b_i (rt),
      .rdata_b_o (rt_data)
   );

   // Decoder. Stores and branches have no destination; dst is left 0 so they
   // can never match in the hazard compare.
   always_comb begin
      ctrl_dec     = '0;
      dst_dec      = 5'd0;
      op_valid     = 1'b1;
      rt_is_source = 1'b0;
      unique case (op)
         OP_RTYPE: begin
            dst_dec            = rd;
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.alu_op    = ALU_FUNCT;
            rt_is_source       = 1'b1;
         end
         OP_ADDI: begin
            dst_dec            = rt;
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.alu_src   = 1'b1;
            ctrl_dec.alu_op    = ALU_ADD;
         end
         OP_LW: begin
            dst_dec            = rt;
            ctrl_dec.reg_write = 1'b1;
            ctrl_dec.mem_read  = 1'b1;
            ctrl_dec.alu_src   = 1'b1;
            ctrl_dec.alu_op    = ALU_ADD;
         end
         OP_SW: begin
            ctrl_dec.mem_write = 1'b1;
            ctrl_dec.alu_src   = 1'b1;
            ctrl_dec.alu_op    = ALU_ADD;
            rt_is_source       = 1'b1;
         end
         OP_BEQ: begin
            ctrl_dec.branch    = 1'b1;
            ctrl_dec.alu_op    = ALU_SUB;
            rt_is_source       = 1'b1;
         end
         default: begin
            op_valid = 1'b0;
         end
      endcase
      // Writing r0 is meaningless; dropping reg_write makes 0x00000000 a NOP.
      if (dst_dec == 5'd0) begin
         ctrl_dec.reg_write = 1'b0;
      end
   end

   // Load-use: the load in ID/EX produces its data too late for EX to
   // forward to the instruction now in ID, so that instruction waits a cycle.
   assign hazard = idex_q.ctrl.mem_read && (idex_q.dst != 5'd0) &&
                   ((idex_q.dst == rs) || ((idex_q.dst == rt) && rt_is_source));

   assign ID_stall_o = hazard && !MEM_do_branch_i;

   // Flush, stall and unknown opcodes all load the same all-zero bubble.
   always_comb begin
      idex_next = '0;
      if (!MEM_do_branch_i && !hazard && op_valid) begin
         idex_next.pc      = IFID_pc_i;
         idex_next.rs_data = rs_data;
         idex_next.rt_data = rt_data;
         idex_next.imm     = imm;
         idex_next.rs      = rs;
         idex_next.rt      = rt;
         idex_next.dst     = dst_dec;
         idex_next.funct   = funct;
         idex_next.ctrl    = ctrl_dec;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idex_q <= '0;
      end else begin
         idex_q <= idex_next;
      end
   end

   assign IDEX_pc_o        = idex_q.pc;
   assign IDEX_rs_data_o   = idex_q.rs_data;
   assign IDEX_rt_data_o   = idex_q.rt_data;
   assign IDEX_imm_o       = idex_q.imm;
   assign IDEX_rs_o        = idex_q.rs;
   assign IDEX_rt_o        = idex_q.rt;
   assign IDEX_dst_o       = idex_q.dst;
   assign IDEX_funct_o     = idex_q.funct;
   assign IDEX_alu_op_o    = idex_q.ctrl.alu_op;
   assign IDEX_alu_src_o   = idex_q.ctrl.alu_src;
   assign IDEX_reg_write_o = idex_q.ctrl.reg_write;
   assign IDEX_mem_read_o  = idex_q.ctrl.mem_read;
   assign IDEX_mem_write_o = idex_q.ctrl.mem_write;
   assign IDEX_branch_o    = idex_q.ctrl.branch;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage
//   Directed bench for id_stage. Each driver call presents one instruction
//   for one cycle and pushes the expected stall (checked mid-cycle) and the
//   expected ID/EX contents (checked after the next rising edge).
module tb_id_stage;

  localparam int W = 156;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] IFID_pc_i;
  logic [31:0] IFID_ir_i;
  logic        MEM_do_branch_i;
  logic        WB_reg_write_i;
  logic [4:0]  WB_dst_i;
  logic [31:0] WB_data_i;
  logic        ID_stall_o;
  logic [31:0] IDEX_pc_o;
  logic [31:0] IDEX_rs_data_o;
  logic [31:0] IDEX_rt_data_o;
  logic [31:0] IDEX_imm_o;
  logic [4:0]  IDEX_rs_o;
  logic [4:0]  IDEX_rt_o;
  logic [4:0]  IDEX_dst_o;
  logic [5:0]  IDEX_funct_o;
  logic [1:0]  IDEX_alu_op_o;
  logic        IDEX_alu_src_o;
  logic        IDEX_reg_write_o;
  logic        IDEX_mem_read_o;
  logic        IDEX_mem_write_o;
  logic        IDEX_branch_o;

  int checks;
  int failures;

  logic [W-1:0] exp_q[$];
  logic         stall_q[$];
  logic [W-1:0] act;

  id_stage dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .IFID_pc_i        (IFID_pc_i),
    .IFID_ir_i        (IFID_ir_i),
    .MEM_do_branch_i  (MEM_do_branch_i),
    .WB_reg_write_i   (WB_reg_write_i),
    .WB_dst_i         (WB_dst_i),
    .WB_data_i        (WB_data_i),
    .ID_stall_o       (ID_stall_o),
    .IDEX_pc_o        (IDEX_pc_o),
    .IDEX_rs_data_o   (IDEX_rs_data_o),
    .IDEX_rt_data_o   (IDEX_rt_data_o),
    .IDEX_imm_o       (IDEX_imm_o),
    .IDEX_rs_o        (IDEX_rs_o),
    .IDEX_rt_o        (IDEX_rt_o),
    .IDEX_dst_o       (IDEX_dst_o),
    .IDEX_funct_o     (IDEX_funct_o),
    .IDEX_alu_op_o    (IDEX_alu_op_o),
    .IDEX_alu_src_o   (IDEX_alu_src_o),
    .IDEX_reg_write_o (IDEX_reg_write_o),
    .IDEX_mem_read_o  (IDEX_mem_read_o),
    .IDEX_mem_write_o (IDEX_mem_write_o),
    .IDEX_branch_o    (IDEX_branch_o)
  );

  assign act = {IDEX_pc_o, IDEX_rs_data_o, IDEX_rt_data_o, IDEX_imm_o,
                IDEX_rs_o, IDEX_rt_o, IDEX_dst_o, IDEX_funct_o,
                IDEX_alu_op_o, IDEX_alu_src_o, IDEX_reg_write_o,
                IDEX_mem_read_o, IDEX_mem_write_o, IDEX_branch_o};

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

  // ---------------- helpers / driver ----------------
  function automatic logic [W-1:0] mk(
    input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd,
    input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] dst, input logic [5:0] funct, input logic [1:0] alu_op,
    input logic src, input logic rw, input logic mr, input logic mw,
    input logic br);
    return {pc, rsd, rtd, imm, rs, rt, dst, funct, alu_op, src, rw, mr, mw, br};
  endfunction

  task automatic drive(
    input logic [31:0] pc, input logic [31:0] ir, input logic br,
    input logic wb_we, input logic [4:0] wb_dst, input logic [31:0] wb_data,
    input logic exp_stall, input logic [W-1:0] exp_idex);
    @(posedge clk_i);
    #2;
    IFID_pc_i       = pc;
    IFID_ir_i       = ir;
    MEM_do_branch_i = br;
    WB_reg_write_i  = wb_we;
    WB_dst_i        = wb_dst;
    WB_data_i       = wb_data;
    stall_q.push_back(exp_stall);
    exp_q.push_back(exp_idex);
  endtask

  // ---------------- scoreboard monitors ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL idex pc=%h: got %h expected %h", e[W-1 -: 32], act, e);
        end
      end
    end
  end

  initial begin
    logic s;
    forever begin
      @(negedge clk_i);
      if (stall_q.size() != 0) begin
        s = stall_q.pop_front();
        checks++;
        if (ID_stall_o !== s) begin
          failures++;
          $display("FAIL stall pc=%h: got %b expected %b", IFID_pc_i, ID_stall_o, s);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    checks          = 0;
    failures        = 0;
    rst_i           = 1'b1;
    IFID_pc_i       = '0;
    IFID_ir_i       = '0;
    MEM_do_branch_i = 1'b0;
    WB_reg_write_i  = 1'b0;
    WB_dst_i        = '0;
    WB_data_i       = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL reset_idex: got %h expected 0", act);
    end
    checks++;
    if (ID_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got %b expected 0", ID_stall_o);
    end
    rst_i = 1'b0;

    // NOP, while WB writes r5=0x1234
    drive(32'h100, 32'h00000000, 0, 1, 5'd5, 32'h1234, 0,
          mk(32'h100, 0, 0, 0, 0, 0, 0, 6'h00, 2'b10, 0, 0, 0, 0, 0));
    // ADDI r6,r5,-1
    drive(32'h104, 32'h20A6FFFF, 0, 0, 0, 0, 0,
          mk(32'h104, 32'h1234, 0, 32'hFFFFFFFF, 5, 6, 6, 6'h3F, 2'b00, 1, 1, 0, 0, 0));
    // add r1,r3,r0 with same-cycle WB r3=0xAA
    drive(32'h108, 32'h00600820, 0, 1, 5'd3, 32'hAA, 0,
          mk(32'h108, 32'hAA, 0, 32'h820, 3, 0, 1, 6'h20, 2'b10, 0, 1, 0, 0, 0));
    // LW r2,0(r1)
    drive(32'h10C, 32'h8C220000, 0, 0, 0, 0, 0,
          mk(32'h10C, 0, 0, 0, 1, 2, 2, 6'h00, 2'b00, 1, 1, 1, 0, 0));
    // ADD r4,r2,r2: load-use, stall and bubble
    drive(32'h110, 32'h00422020, 0, 0, 0, 0, 1, '0);
    // held ADD issues; WB r2=0x55 written through
    drive(32'h110, 32'h00422020, 0, 1, 5'd2, 32'h55, 0,
          mk(32'h110, 32'h55, 32'h55, 32'h2020, 2, 2, 4, 6'h20, 2'b10, 0, 1, 0, 0, 0));
    // LW r2,4(r0)
    drive(32'h114, 32'h8C020004, 0, 0, 0, 0, 0,
          mk(32'h114, 0, 32'h55, 32'h4, 0, 2, 2, 6'h04, 2'b00, 1, 1, 1, 0, 0));
    // ADDI r2,r0,7: rt is only a destination, no stall
    drive(32'h118, 32'h20020007, 0, 0, 0, 0, 0,
          mk(32'h118, 0, 32'h55, 32'h7, 0, 2, 2, 6'h07, 2'b00, 1, 1, 0, 0, 0));
    // LW r7,0(r0)
    drive(32'h11C, 32'h8C070000, 0, 0, 0, 0, 0,
          mk(32'h11C, 0, 0, 0, 0, 7, 7, 6'h00, 2'b00, 1, 1, 1, 0, 0));
    // SW r7,8(r0): rt is a source, stall
    drive(32'h120, 32'hAC070008, 0, 0, 0, 0, 1, '0);
    // held SW issues
    drive(32'h120, 32'hAC070008, 0, 0, 0, 0, 0,
          mk(32'h120, 0, 0, 32'h8, 0, 7, 0, 6'h08, 2'b00, 1, 0, 0, 1, 0));
    // LW r7,0(r0)
    drive(32'h124, 32'h8C070000, 0, 0, 0, 0, 0,
          mk(32'h124, 0, 0, 0, 0, 7, 7, 6'h00, 2'b00, 1, 1, 1, 0, 0));
    // BEQ r0,r7 hazard with a taken branch in MEM: no stall, bubble
    drive(32'h128, 32'h10070002, 1, 0, 0, 0, 0, '0);
    // BEQ r0,r7 at redirected pc, no hazard
    drive(32'h200, 32'h10070002, 0, 0, 0, 0, 0,
          mk(32'h200, 0, 0, 32'h2, 0, 7, 0, 6'h02, 2'b01, 0, 0, 0, 0, 1));
    // unknown opcode: bubble
    drive(32'h204, 32'hFC000000, 0, 0, 0, 0, 0, '0);
    // ADDI r6,r5,-1 again, with an unrelated WB to r9
    drive(32'h208, 32'h20A6FFFF, 0, 1, 5'd9, 32'h99, 0,
          mk(32'h208, 32'h1234, 0, 32'hFFFFFFFF, 5, 6, 6, 6'h3F, 2'b00, 1, 1, 0, 0, 0));

    // asynchronous reset mid-stream, with a coincident WB write to r5
    @(posedge clk_i);
    #3;
    WB_reg_write_i = 1'b1;
    WB_dst_i       = 5'd5;
    WB_data_i      = 32'hBEEF;
    rst_i          = 1'b1;
    #1;
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL async_reset_idex: got %h expected 0", act);
    end
    checks++;
    if (ID_stall_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_stall: got %b expected 0", ID_stall_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    WB_reg_write_i = 1'b0;
    rst_i          = 1'b0;

    // r5 must read 0 after reset
    drive(32'h20C, 32'h20A6FFFF, 0, 0, 0, 0, 0,
          mk(32'h20C, 0, 0, 32'hFFFFFFFF, 5, 6, 6, 6'h3F, 2'b00, 1, 1, 0, 0, 0));

    // drain and report
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    checks++;
    if ((exp_q.size() != 0) || (stall_q.size() != 0)) begin
      failures++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", exp_q.size(), stall_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
